// File: rtl/exec_unit_mc_if.sv
// Instruction/result bundle between the front end and exec_unit_mc.
// Master issues opcode/operand, slave returns O, handshake and flags.
interface exec_unit_mc_if #(
   parameter int IN_W  = 4,
   parameter int OUT_W = 8
);
   logic              start;
   logic [3:0]        opcode;
   logic [2*IN_W-1:0] operand;
   logic [OUT_W-1:0]  cpu_out;
   logic              busy;
   logic              done;
   logic              skip;
   logic              zero_flag;
   logic              carry_flag;

   modport master (
      output start, opcode, operand,
      input  cpu_out, busy, done, skip, zero_flag, carry_flag
   );

   modport slave (
      input  start, opcode, operand,
      output cpu_out, busy, done, skip, zero_flag, carry_flag
   );
endinterface

// File: rtl/exec_unit_mc.sv
// Multi-cycle execution unit: ALU, ACC/O registers, flags, shift-add MUL/MAC.
// EXEC_UNIT_MUL_EN builds the multiplier; without it opcodes 11/12 are NOPs.
module exec_unit_mc #(
   parameter int IN_W  = 4,
   parameter int OUT_W = 8
) (
   input  logic          clk,
   input  logic          reset,
   exec_unit_mc_if.slave eu
);
   if (OUT_W < 2*IN_W || IN_W < 2) begin : g_bad_cfg
      $error("exec_unit_mc: need IN_W >= 2 and OUT_W >= 2*IN_W");
   end

   localparam logic [3:0] OP_LDA = 4'd1;
   localparam logic [3:0] OP_LDB = 4'd2;
   localparam logic [3:0] OP_ADD = 4'd3;
   localparam logic [3:0] OP_SUB = 4'd4;
   localparam logic [3:0] OP_AND = 4'd5;
   localparam logic [3:0] OP_OR  = 4'd6;
   localparam logic [3:0] OP_XOR = 4'd7;
   localparam logic [3:0] OP_INV = 4'd8;
   localparam logic [3:0] OP_LSH = 4'd9;
   localparam logic [3:0] OP_RSH = 4'd10;
   localparam logic [3:0] OP_MUL = 4'd11;
   localparam logic [3:0] OP_MAC = 4'd12;
   localparam logic [3:0] OP_LDO = 4'd13;
   localparam logic [3:0] OP_CLR = 4'd14;
   localparam logic [3:0] OP_SNZ = 4'd15;

   logic [IN_W-1:0]  a_q, a_d, b_q, b_d;
   logic [OUT_W-1:0] acc_q, acc_d, o_q, o_d;
   logic [OUT_W-1:0] a_x, b_x;
   logic             done_q, done_d, skip_q, skip_d;
   logic             z_q, z_d, c_q, c_d;
   logic             flag_wr, accept, busy;

`ifdef EXEC_UNIT_MUL_EN
   localparam int CW = $clog2(IN_W);
   typedef enum logic [1:0] {IDLE, MUL_ITER, MAC_ACC} state_e;
   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [OUT_W-1:0] mcand_q, mcand_d, prod_q, prod_d, prod_n;
   logic [IN_W-1:0]  mplier_q, mplier_d;
   logic             mac_q, mac_d;
   logic [OUT_W:0]   sum;

   assign busy = (state_q != IDLE);
`else
   assign busy = 1'b0;
`endif

   assign accept = eu.start & ~busy;
   assign a_x    = OUT_W'(a_q);
   assign b_x    = OUT_W'(b_q);

   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      o_d     = o_q;
      z_d     = z_q;
      c_d     = c_q;
      done_d  = 1'b0;
      skip_d  = 1'b0;
      flag_wr = 1'b0;
`ifdef EXEC_UNIT_MUL_EN
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      prod_n   = prod_q;
      mac_d    = mac_q;
      sum      = '0;
`endif
      if (accept) begin
         done_d = 1'b1;
         unique case (eu.opcode)
            OP_LDA: a_d = eu.operand[2*IN_W-1:IN_W];
            OP_LDB: b_d = eu.operand[IN_W-1:0];
            OP_ADD: begin acc_d = a_x + b_x; c_d = 1'b0; flag_wr = 1'b1; end
            OP_SUB: begin acc_d = a_x - b_x; c_d = (a_q < b_q); flag_wr = 1'b1; end
            OP_AND: begin acc_d = a_x & b_x; c_d = 1'b0; flag_wr = 1'b1; end
            OP_OR:  begin acc_d = a_x | b_x; c_d = 1'b0; flag_wr = 1'b1; end
            OP_XOR: begin acc_d = a_x ^ b_x; c_d = 1'b0; flag_wr = 1'b1; end
            OP_INV: begin acc_d = ~acc_q; c_d = 1'b0; flag_wr = 1'b1; end
            OP_LSH: begin
               acc_d   = acc_q << 1;
               c_d     = acc_q[OUT_W-1];
               flag_wr = 1'b1;
            end
            OP_RSH: begin
               acc_d   = acc_q >> 1;
               c_d     = acc_q[0];
               flag_wr = 1'b1;
            end
`ifdef EXEC_UNIT_MUL_EN
            OP_MUL, OP_MAC: begin
               done_d   = 1'b0;
               mcand_d  = a_x;
               mplier_d = b_q;
               prod_d   = '0;
               cnt_d    = '0;
               mac_d    = (eu.opcode == OP_MAC);
               state_d  = MUL_ITER;
            end
`endif
            OP_LDO: o_d = acc_q;
            OP_CLR: begin acc_d = '0; c_d = 1'b0; flag_wr = 1'b1; end
            OP_SNZ: skip_d = |acc_q;
            default: ;
         endcase
      end
`ifdef EXEC_UNIT_MUL_EN
      unique case (state_q)
         MUL_ITER: begin
            prod_n   = mplier_q[0] ? prod_q + mcand_q : prod_q;
            prod_d   = prod_n;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(IN_W-1)) begin
               if (mac_q) begin
                  state_d = MAC_ACC;
               end else begin
                  acc_d   = prod_n;
                  c_d     = 1'b0;
                  flag_wr = 1'b1;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         MAC_ACC: begin
            sum     = {1'b0, acc_q} + {1'b0, prod_q};
            acc_d   = sum[OUT_W-1:0];
            c_d     = sum[OUT_W];
            flag_wr = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: ;
      endcase
`endif
      if (flag_wr) z_d = (acc_d == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q    <= '0;
         b_q    <= '0;
         acc_q  <= '0;
         o_q    <= '0;
         z_q    <= 1'b1;
         c_q    <= 1'b0;
         done_q <= 1'b0;
         skip_q <= 1'b0;
`ifdef EXEC_UNIT_MUL_EN
         state_q  <= IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         mac_q    <= 1'b0;
`endif
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         acc_q  <= acc_d;
         o_q    <= o_d;
         z_q    <= z_d;
         c_q    <= c_d;
         done_q <= done_d;
         skip_q <= skip_d;
`ifdef EXEC_UNIT_MUL_EN
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         mac_q    <= mac_d;
`endif
      end
   end

   assign eu.cpu_out    = o_q;
   assign eu.busy       = busy;
   assign eu.done       = done_q;
   assign eu.skip       = skip_q;
   assign eu.zero_flag  = z_q;
   assign eu.carry_flag = c_q;
endmodule

// File: tb/tb_exec_unit_mc.sv
// Scoreboard bench for exec_unit_mc: directed instructions, expected
// responses queued at issue and checked by a done-triggered monitor.
module tb_exec_unit_mc;
   localparam int IN_W  = 4;
   localparam int OUT_W = 8;

   logic clk = 1'b0;
   logic reset;

   exec_unit_mc_if #(.IN_W(IN_W), .OUT_W(OUT_W)) eu ();

   exec_unit_mc #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .eu    (eu)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [7:0] out;
      logic       z;
      logic       c;
      logic       skip;
      int         lat;
      int         issue;
   } exp_t;

   exp_t sbq[$];
   exp_t me;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Every done pulse must match the oldest outstanding instruction.
   always @(negedge clk) begin
      if (eu.done === 1'b1) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected done at cycle %0d: got done=1 expected no done", cyc);
         end else begin
            me = sbq.pop_front();
            chk({me.name, " cpu_out"}, 32'(eu.cpu_out), 32'(me.out));
            chk({me.name, " zero"}, 32'(eu.zero_flag), 32'(me.z));
            chk({me.name, " carry"}, 32'(eu.carry_flag), 32'(me.c));
            chk({me.name, " skip"}, 32'(eu.skip), 32'(me.skip));
            chk({me.name, " latency"}, 32'(cyc - me.issue), 32'(me.lat));
         end
      end
   end

   // Called at a negedge; returns at the negedge where done is seen.
   task automatic issue(string nm, logic [3:0] op, logic [7:0] opnd,
                        logic [7:0] eo, logic ez, logic ec, logic esk,
                        int elat, bit inject);
      exp_t e;
      int   n;
      e.name  = nm;
      e.out   = eo;
      e.z     = ez;
      e.c     = ec;
      e.skip  = esk;
      e.lat   = elat;
      e.issue = cyc + 1;
      sbq.push_back(e);
      eu.start   = 1'b1;
      eu.opcode  = op;
      eu.operand = opnd;
      @(negedge clk);
      eu.start   = 1'b0;
      eu.opcode  = 4'd0;
      eu.operand = 8'h00;
      n = 0;
      if (inject) begin
         chk({nm, " busy"}, 32'(eu.busy), 32'd1);
         eu.start   = 1'b1;
         eu.opcode  = 4'd1;
         eu.operand = 8'h50;
         @(negedge clk);
         eu.start   = 1'b0;
         eu.opcode  = 4'd0;
         eu.operand = 8'h00;
         n = 1;
      end
      while (eu.done !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (eu.done !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: got no done expected done within 20 cycles", nm);
         sbq.delete();
      end
   endtask

   logic [7:0] o6;

   initial begin
      reset      = 1'b1;
      eu.start   = 1'b0;
      eu.opcode  = 4'd0;
      eu.operand = 8'h00;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("reset cpu_out", 32'(eu.cpu_out), 32'h0);
      chk("reset busy", 32'(eu.busy), 32'd0);
      chk("reset done", 32'(eu.done), 32'd0);
      chk("reset skip", 32'(eu.skip), 32'd0);
      chk("reset zero", 32'(eu.zero_flag), 32'd1);
      chk("reset carry", 32'(eu.carry_flag), 32'd0);

      issue("LDA A0", 4'd1, 8'hA0, 8'h00, 1, 0, 0, 0, 0);
      issue("LDB 03", 4'd2, 8'h03, 8'h00, 1, 0, 0, 0, 0);
      issue("ADD", 4'd3, 8'h00, 8'h00, 0, 0, 0, 0, 0);
      issue("LDO 0D", 4'd13, 8'h00, 8'h0D, 0, 0, 0, 0, 0);

      issue("LDA 30", 4'd1, 8'h30, 8'h0D, 0, 0, 0, 0, 0);
      issue("LDB 05", 4'd2, 8'h05, 8'h0D, 0, 0, 0, 0, 0);
      issue("SUB", 4'd4, 8'h00, 8'h0D, 0, 1, 0, 0, 0);
      issue("RSH", 4'd10, 8'h00, 8'h0D, 0, 0, 0, 0, 0);
      issue("LSH", 4'd9, 8'h00, 8'h0D, 0, 0, 0, 0, 0);
      issue("LDO FE", 4'd13, 8'h00, 8'hFE, 0, 0, 0, 0, 0);

      issue("LDA C0", 4'd1, 8'hC0, 8'hFE, 0, 0, 0, 0, 0);
      issue("LDB 0A", 4'd2, 8'h0A, 8'hFE, 0, 0, 0, 0, 0);
      issue("AND", 4'd5, 8'h00, 8'hFE, 0, 0, 0, 0, 0);
      issue("LDO 08", 4'd13, 8'h00, 8'h08, 0, 0, 0, 0, 0);
      issue("OR", 4'd6, 8'h00, 8'h08, 0, 0, 0, 0, 0);
      issue("LDO 0E", 4'd13, 8'h00, 8'h0E, 0, 0, 0, 0, 0);
      issue("XOR", 4'd7, 8'h00, 8'h0E, 0, 0, 0, 0, 0);
      issue("INV", 4'd8, 8'h00, 8'h0E, 0, 0, 0, 0, 0);
      issue("LDO F9", 4'd13, 8'h00, 8'hF9, 0, 0, 0, 0, 0);
      issue("LSH F9", 4'd9, 8'h00, 8'hF9, 0, 1, 0, 0, 0);
      issue("LDO F2", 4'd13, 8'h00, 8'hF2, 0, 1, 0, 0, 0);

`ifdef EXEC_UNIT_MUL_EN
      issue("LDA F0", 4'd1, 8'hF0, 8'hF2, 0, 1, 0, 0, 0);
      issue("LDB 0F", 4'd2, 8'h0F, 8'hF2, 0, 1, 0, 0, 0);
      issue("MUL", 4'd11, 8'h00, 8'hF2, 0, 0, 0, 4, 1);
      issue("LDO E1", 4'd13, 8'h00, 8'hE1, 0, 0, 0, 0, 0);
      issue("MAC", 4'd12, 8'h00, 8'hE1, 0, 1, 0, 5, 0);
      issue("LDO C2", 4'd13, 8'h00, 8'hC2, 0, 1, 0, 0, 0);

      eu.start  = 1'b1;
      eu.opcode = 4'd11;
      @(negedge clk);
      eu.start  = 1'b0;
      eu.opcode = 4'd0;
      chk("MUL abort busy1", 32'(eu.busy), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort busy", 32'(eu.busy), 32'd0);
      chk("abort done", 32'(eu.done), 32'd0);
      chk("abort zero", 32'(eu.zero_flag), 32'd1);
      chk("abort carry", 32'(eu.carry_flag), 32'd0);
      chk("abort cpu_out", 32'(eu.cpu_out), 32'h0);
      issue("LDA 10", 4'd1, 8'h10, 8'h00, 1, 0, 0, 0, 0);
      issue("LDB 01", 4'd2, 8'h01, 8'h00, 1, 0, 0, 0, 0);
      issue("ADD 1+1", 4'd3, 8'h00, 8'h00, 0, 0, 0, 0, 0);
      issue("LDO 02", 4'd13, 8'h00, 8'h02, 0, 0, 0, 0, 0);
      o6 = 8'h02;
`else
      o6 = 8'hF2;
`endif

      issue("CLR", 4'd14, 8'h00, o6, 1, 0, 0, 0, 0);
      issue("SNZ zero", 4'd15, 8'h00, o6, 1, 0, 0, 0, 0);
      issue("LDA 10 b", 4'd1, 8'h10, o6, 1, 0, 0, 0, 0);
      issue("LDB 00", 4'd2, 8'h00, o6, 1, 0, 0, 0, 0);
      issue("ADD 1+0", 4'd3, 8'h00, o6, 0, 0, 0, 0, 0);
      issue("SNZ nz", 4'd15, 8'h00, o6, 0, 0, 1, 0, 0);
`ifndef EXEC_UNIT_MUL_EN
      issue("MUL nop", 4'd11, 8'h00, o6, 0, 0, 0, 0, 0);
      chk("MUL nop busy", 32'(eu.busy), 32'd0);
      issue("MAC nop", 4'd12, 8'h00, o6, 0, 0, 0, 0, 0);
`endif
      issue("LDO 01", 4'd13, 8'h00, 8'h01, 0, 0, 0, 0, 0);

      repeat (3) @(negedge clk);
      chk("scoreboard drained", 32'(sbq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish before 100000");
      $fatal(1, "watchdog");
   end
endmodule
